scan_index_seq: RTL and testbench
=================================

// Module: scan_index_seq
// PURPOSE
//   Timed 3-bit index sequencer feeding the 3-to-8 one-hot decoder stage.
//   Sel_out connects directly to the decoder's Data_in.
//   Steps the index once every PRESCALE enabled clocks, up or down, with wrap-around.
//   Supports synchronous load of an arbitrary start index.
//   Drives channel/LED scanning; step_pulse and wrap_pulse mark each advance for downstream logic.
// PARAMETERS
//   PRESCALE  4  enabled clocks per index step; legal range 1..255
//   PRE_W     8  prescaler counter width; must hold PRESCALE-1
// PORTS
//   clk         in   1      single clock, all state on rising edge
//   rst_n       in   1      reset, asynchronous assert, active-low
//   en          in   1      1 = prescaler counts and index may step; 0 = freeze
//   dir         in   1      0 = count up, 1 = count down (ignored in bounce mode)
//   load        in   1      synchronous load strobe
//   load_val    in   3      index value taken on load
//   bounce      in   1      1 = ping-pong mode (only when SCAN_BOUNCE_EN defined)
//   Sel_out     out  3      current index, registered; to decoder Data_in
//   step_pulse  out  1      1-cycle high in the cycle Sel_out shows a stepped value
//   wrap_pulse  out  1      1-cycle high when step went 7->0 (up) or 0->7 (down)
// BEHAVIOUR
//   Reset values (rst_n=0, asynchronous): Sel_out=3'd0, pre_cnt=0, step_pulse=0, wrap_pulse=0, bdir=up.
//   Priority each edge, highest first: load > en.
//   load=1:
//     Sel_out<=load_val; pre_cnt<=0; step_pulse=0; wrap_pulse=0 next cycle.
//     load applies regardless of en.
//   load=0, en=0:
//     pre_cnt and Sel_out hold; step_pulse/wrap_pulse deassert.
//   load=0, en=1, pre_cnt!=PRESCALE-1:
//     pre_cnt<=pre_cnt+1; no step.
//   load=0, en=1, pre_cnt==PRESCALE-1 (tick):
//     pre_cnt<=0; Sel_out<=next index; step_pulse<=1.
//   Next index, non-bounce: dir=0 -> Sel_out+1 mod 8; dir=1 -> Sel_out-1 mod 8.
//   Wrap: wrap_pulse<=1 on 7->0 when up, and on 0->7 when down.
//   Latency: first step lands PRESCALE enabled cycles after reset release or load.
//     Outputs are registered, so step_pulse coincides with the new Sel_out.
//   PRESCALE=1: steps on every enabled cycle; step_pulse stays high while en=1.
//   dir change mid-count does not reset pre_cnt; the new direction applies at the next tick.
//   en toggling mid-count: pre_cnt resumes from its held value, with no lost or extra ticks.
//   rst_n asserted mid-operation: all state returns to reset values immediately, with no clock needed.
// CONFIGURATION
//   SCAN_BOUNCE_EN defined: bounce input is live.
//     bounce=1 uses internal bdir; at tick: bdir=up and Sel_out==7 -> bdir<=down, Sel_out<=6.
//     bdir=down and Sel_out==0 -> bdir<=up, Sel_out<=1; otherwise step per bdir.
//     wrap_pulse is high on each turn-around step; dir input is ignored.
//     load sets bdir<=up.
//   SCAN_BOUNCE_EN undefined: bounce port still exists but is ignored; no bdir flop.
//     Behaviour is the pure wrap counter.
// TESTING (PRESCALE=4 unless noted)
//   1. Reset release, en=1, dir=0:
//      Sel_out 1,2,3 after 4,8,12 clks with step_pulse each time.
//      At 32 clks Sel_out=0 and wrap_pulse=1 for 1 clk.
//   2. dir=1 from reset: Sel_out=7 after 4 clks with wrap_pulse=1; then 6 after 8 clks.
//   3. Sel_out=2 with pre_cnt=2, pulse load=1 with load_val=5:
//      Sel_out=5 next clk, no step_pulse; Sel_out=6 exactly 4 enabled clks later.
//   4. en=0 for 10 clks after 2 counts: Sel_out and pre_cnt frozen.
//      Re-enable: step occurs after 2 more clks.
//   5. rst_n low between clock edges mid-count: Sel_out=0 and pulses=0 immediately.
//      After release, first step after 4 clks.
//   6. SCAN_BOUNCE_EN, bounce=1, PRESCALE=1: Sel_out sequence 1..7,6..0,1.
//      wrap_pulse is high at 7->6 and at 0->1.

Source files
------------

// File: rtl/scan_index_seq.sv
// -----------------------------------------------------------------------------
// scan_index_seq
//   Timed 3-bit index sequencer that feeds a 3-to-8 one-hot decoder.
//   The index advances once every PRESCALE enabled clocks, either up or down,
//   and wraps around. A synchronous load sets an arbitrary start index.
//   step_pulse and wrap_pulse mark each advance for downstream logic.
//
// Optional feature macro: SCAN_BOUNCE_EN
//   When defined, the bounce input is live: with bounce=1 the index ping-pongs
//   0..7..0 using an internal direction flop, and dir is ignored.
//   When undefined, bounce is accepted but has no effect.
//
// Parameters
//   PRESCALE   enabled clocks per index step (1..255)
//   PRE_W      prescaler counter width; must hold PRESCALE-1
//
// Ports
//   clk         in   1  clock, all state updates on the rising edge
//   rst_n       in   1  asynchronous active-low reset
//   en          in   1  1 = prescaler counts and the index may step, 0 = freeze
//   dir         in   1  0 = count up, 1 = count down
//   load        in   1  synchronous load strobe (takes priority over en)
//   load_val    in   3  index loaded when load=1
//   bounce      in   1  ping-pong mode select (SCAN_BOUNCE_EN builds only)
//   Sel_out     out  3  current index, registered; drives decoder Data_in
//   step_pulse  out  1  high for the cycle Sel_out shows a newly stepped value
//   wrap_pulse  out  1  high on 7->0 / 0->7 wraps, or on bounce turn-arounds
// -----------------------------------------------------------------------------
module scan_index_seq #(
    parameter int unsigned PRESCALE = 4,
    parameter int unsigned PRE_W    = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    input  logic [2:0] load_val,
    input  logic       bounce,
    output logic [2:0] Sel_out,
    output logic       step_pulse,
    output logic       wrap_pulse
);

    localparam logic [PRE_W-1:0] LP_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [PRE_W-1:0] LP_ONE  = PRE_W'(1);

    logic [PRE_W-1:0] r_pre_cnt;
    logic [2:0]       r_sel;
    logic             r_step;
    logic             r_wrap;

    logic             w_tick;
    logic [2:0]       w_next_sel;
    logic             w_next_wrap;

    // The tick is the last enabled cycle of a prescale period; the index
    // changes on that edge so the new value appears together with step_pulse.
    assign w_tick = (r_pre_cnt == LP_LAST);

`ifdef SCAN_BOUNCE_EN
    // Ping-pong direction: 0 = up, 1 = down.
    logic r_bdir;
    logic w_next_bdir;

    always_comb begin
        w_next_sel  = r_sel;
        w_next_wrap = 1'b0;
        w_next_bdir = r_bdir;
        if (bounce) begin
            if (!r_bdir && (r_sel == 3'd7)) begin
                // Turn around at the top end instead of wrapping.
                w_next_sel  = 3'd6;
                w_next_bdir = 1'b1;
                w_next_wrap = 1'b1;
            end else if (r_bdir && (r_sel == 3'd0)) begin
                w_next_sel  = 3'd1;
                w_next_bdir = 1'b0;
                w_next_wrap = 1'b1;
            end else if (r_bdir) begin
                w_next_sel = r_sel - 3'd1;
            end else begin
                w_next_sel = r_sel + 3'd1;
            end
        end else if (dir) begin
            w_next_sel  = r_sel - 3'd1;
            w_next_wrap = (r_sel == 3'd0);
        end else begin
            w_next_sel  = r_sel + 3'd1;
            w_next_wrap = (r_sel == 3'd7);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bdir <= 1'b0;
        end else if (load) begin
            r_bdir <= 1'b0;
        end else if (en && w_tick) begin
            r_bdir <= w_next_bdir;
        end
    end
`else
    // Bounce mode is not built; the port is kept so both builds share a pinout.
    logic w_unused_bounce;
    assign w_unused_bounce = bounce;

    always_comb begin
        w_next_sel  = r_sel;
        w_next_wrap = 1'b0;
        if (dir) begin
            w_next_sel  = r_sel - 3'd1;
            w_next_wrap = (r_sel == 3'd0);
        end else begin
            w_next_sel  = r_sel + 3'd1;
            w_next_wrap = (r_sel == 3'd7);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre_cnt <= '0;
            r_sel     <= 3'd0;
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (load) begin
            // Load restarts the prescale period so the first step from the
            // loaded value lands a full PRESCALE enabled cycles later.
            r_pre_cnt <= '0;
            r_sel     <= load_val;
            r_step    <= 1'b0;
            r_wrap    <= 1'b0;
        end else if (en) begin
            if (w_tick) begin
                r_pre_cnt <= '0;
                r_sel     <= w_next_sel;
                r_step    <= 1'b1;
                r_wrap    <= w_next_wrap;
            end else begin
                r_pre_cnt <= r_pre_cnt + LP_ONE;
                r_step    <= 1'b0;
                r_wrap    <= 1'b0;
            end
        end else begin
            // Frozen: the count and index hold so no tick is lost or added.
            r_step <= 1'b0;
            r_wrap <= 1'b0;
        end
    end

    assign Sel_out    = r_sel;
    assign step_pulse = r_step;
    assign wrap_pulse = r_wrap;

endmodule

// File: tb/tb_scan_index_seq.sv
// -----------------------------------------------------------------------------
// tb_scan_index_seq
//   Self-checking bench for scan_index_seq. A reference model of the sequencer
//   (PRESCALE=4 instance) predicts the outputs for every clock; predictions are
//   pushed into a scoreboard queue as stimulus is applied and popped/compared
//   one time unit after the rising edge. A second PRESCALE=1 instance covers
//   single-cycle stepping and, when SCAN_BOUNCE_EN is defined, bounce mode.
// -----------------------------------------------------------------------------
module tb_scan_index_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;

    // PRESCALE=4 instance
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] load_val = 3'd0;
    logic       bounce = 1'b0;
    logic [2:0] Sel_out;
    logic       step_pulse;
    logic       wrap_pulse;

    // PRESCALE=1 instance
    logic       en_p1 = 1'b0;
    logic       load_p1 = 1'b0;
    logic [2:0] load_val_p1 = 3'd0;
    logic       bounce_p1 = 1'b0;
    logic [2:0] sel_p1;
    logic       step_p1;
    logic       wrap_p1;

    int n_checks = 0;
    int n_fail   = 0;
    int n_txn    = 0;

    // Reference model state and scoreboard
    logic [2:0] m_sel = 3'd0;
    int         m_pre = 0;
    logic [4:0] sb_q[$];

    scan_index_seq #(.PRESCALE(4), .PRE_W(8)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .dir        (dir),
        .load       (load),
        .load_val   (load_val),
        .bounce     (bounce),
        .Sel_out    (Sel_out),
        .step_pulse (step_pulse),
        .wrap_pulse (wrap_pulse)
    );

    scan_index_seq #(.PRESCALE(1), .PRE_W(8)) u_dut_p1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en_p1),
        .dir        (1'b0),
        .load       (load_p1),
        .load_val   (load_val_p1),
        .bounce     (bounce_p1),
        .Sel_out    (sel_p1),
        .step_pulse (step_p1),
        .wrap_pulse (wrap_p1)
    );

    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Predict one clock from the current inputs, push the prediction, clock,
    // then pop and compare against the DUT.
    task automatic cyc();
        logic [2:0] ns;
        logic       nstep;
        logic       nwrap;
        int         npre;
        logic [4:0] e;
        ns = m_sel; npre = m_pre; nstep = 1'b0; nwrap = 1'b0;
        if (load) begin
            ns = load_val;
            npre = 0;
        end else if (en) begin
            if (m_pre == 3) begin
                npre  = 0;
                nstep = 1'b1;
                if (dir) begin
                    ns    = m_sel - 3'd1;
                    nwrap = (m_sel == 3'd0);
                end else begin
                    ns    = m_sel + 3'd1;
                    nwrap = (m_sel == 3'd7);
                end
            end else begin
                npre = m_pre + 1;
            end
        end
        m_sel = ns;
        m_pre = npre;
        sb_q.push_back({ns, nstep, nwrap});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        n_txn++;
        $display("txn %0d sel=%0d step=%0d wrap=%0d", n_txn, Sel_out, step_pulse, wrap_pulse);
        chk_val("sb_sel",  32'(Sel_out),    32'(e[4:2]));
        chk_val("sb_step", 32'(step_pulse), 32'(e[1]));
        chk_val("sb_wrap", 32'(wrap_pulse), 32'(e[0]));
    endtask

    // Assert reset between clock edges and check that it acts without a clock.
    task automatic reset_and_check(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        m_sel = 3'd0;
        m_pre = 0;
        sb_q.delete();
        chk_val({tag, "_sel"},  32'(Sel_out),    32'd0);
        chk_val({tag, "_step"}, 32'(step_pulse), 32'd0);
        chk_val({tag, "_wrap"}, 32'(wrap_pulse), 32'd0);
        chk_val({tag, "_p1sel"}, 32'(sel_p1),    32'd0);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #1;
        reset_and_check("rst0");

        // 1: count up from reset, wrap after 32 clocks
        en = 1'b1; dir = 1'b0;
        for (int i = 1; i <= 33; i++) begin
            cyc();
            if (i == 4 || i == 8 || i == 12) begin
                chk_val("t1_sel",  32'(Sel_out), 32'(i / 4));
                chk_val("t1_step", 32'(step_pulse), 32'd1);
            end
            if (i == 32) begin
                chk_val("t1_wrap_sel", 32'(Sel_out), 32'd0);
                chk_val("t1_wrap",     32'(wrap_pulse), 32'd1);
            end
            if (i == 33) chk_val("t1_wrap_clr", 32'(wrap_pulse), 32'd0);
        end

        // 2: count down from reset
        reset_and_check("rst2");
        en = 1'b1; dir = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            if (i == 4) begin
                chk_val("t2_sel7", 32'(Sel_out), 32'd7);
                chk_val("t2_wrap", 32'(wrap_pulse), 32'd1);
            end
            if (i == 8) begin
                chk_val("t2_sel6",  32'(Sel_out), 32'd6);
                chk_val("t2_nowrap", 32'(wrap_pulse), 32'd0);
            end
        end

        // 3: load mid-count (Sel_out=2, pre_cnt=2)
        reset_and_check("rst3");
        en = 1'b1; dir = 1'b0;
        repeat (10) cyc();
        load = 1'b1; load_val = 3'd5;
        cyc();
        chk_val("t3_load_sel",  32'(Sel_out), 32'd5);
        chk_val("t3_load_step", 32'(step_pulse), 32'd0);
        load = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (i == 3) chk_val("t3_hold", 32'(Sel_out), 32'd5);
            if (i == 4) chk_val("t3_step", 32'(Sel_out), 32'd6);
        end

        // 4: freeze for 10 clocks after 2 counts, then resume
        reset_and_check("rst4");
        en = 1'b1;
        repeat (2) cyc();
        en = 1'b0;
        repeat (10) begin
            cyc();
            chk_val("t4_frozen", 32'(Sel_out), 32'd0);
        end
        en = 1'b1;
        cyc();
        chk_val("t4_pre_hold", 32'(step_pulse), 32'd0);
        cyc();
        chk_val("t4_resume_sel",  32'(Sel_out), 32'd1);
        chk_val("t4_resume_step", 32'(step_pulse), 32'd1);

        // load while disabled, then wrap from 7
        en = 1'b0; load = 1'b1; load_val = 3'd7;
        cyc();
        chk_val("t4_load_dis", 32'(Sel_out), 32'd7);
        load = 1'b0; en = 1'b1;
        repeat (4) cyc();
        chk_val("t4_wrap_up", 32'(wrap_pulse), 32'd1);

        // 5: async reset mid-count while step_pulse is high
        reset_and_check("rst5a");
        en = 1'b1;
        repeat (4) cyc();
        chk_val("t5_pre_step", 32'(step_pulse), 32'd1);
        reset_and_check("t5_async");
        for (int i = 1; i <= 4; i++) begin
            cyc();
            if (i == 3) chk_val("t5_no_early", 32'(Sel_out), 32'd0);
            if (i == 4) chk_val("t5_first",    32'(Sel_out), 32'd1);
        end

        // random traffic: dir flips mid-count, en gaps, occasional loads
        for (int i = 0; i < 120; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) dir = ~dir;
            load = ($urandom_range(0, 15) == 0);
            load_val = 3'($urandom_range(0, 7));
            cyc();
        end
        load = 1'b0; en = 1'b0;

        // PRESCALE=1: steps every enabled cycle, step_pulse held high
        reset_and_check("rst7");
        en_p1 = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            cyc();
            chk_val("p1_sel",  32'(sel_p1),  32'(i % 8));
            chk_val("p1_step", 32'(step_p1), 32'd1);
            chk_val("p1_wrap", 32'(wrap_p1), 32'((i % 8) == 0));
        end
        en_p1 = 1'b0;
        cyc();
        chk_val("p1_step_off", 32'(step_p1), 32'd0);

`ifdef SCAN_BOUNCE_EN
        // 6: bounce sequence 1..7,6..0,1 with turn-around wrap pulses
        load_p1 = 1'b1; load_val_p1 = 3'd0;
        cyc();
        load_p1 = 1'b0; en_p1 = 1'b1; bounce_p1 = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            cyc();
            chk_val("bnc_sel",  32'(sel_p1), 32'((k <= 7) ? k : ((k <= 14) ? (14 - k) : (k - 14))));
            chk_val("bnc_wrap", 32'(wrap_p1), 32'((k == 8) || (k == 15)));
        end
        en_p1 = 1'b0; bounce_p1 = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
